// File: rtl/gru_sequence_controller.sv
// gru_sequence_controller: upstream and feedback stage for gru_cell_parallel.
// Assembles each D-element x_t from an element stream and pulses the cell's
// start input. Captures h_t into the hidden-state register when the cell
// reports done. After len timesteps, streams the final hidden state out.
`timescale 1ns/1ps
module gru_sequence_controller #(
  parameter int D          = 64,
  parameter int H          = 16,
  parameter int DATA_WIDTH = 15,
  parameter int T_MAX      = 32,
  localparam int SLW       = $clog2(T_MAX + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              seq_start,
  input  logic [SLW-1:0]                    seq_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_WIDTH-1:0]      in_data,
  output logic                              cell_start,
  output logic [D-1:0][DATA_WIDTH-1:0]      cell_x_t,
  output logic [H-1:0][DATA_WIDTH-1:0]      cell_h_prev,
  input  logic [H-1:0][DATA_WIDTH-1:0]      cell_h_t,
  input  logic                              cell_done,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [DATA_WIDTH-1:0]      out_data,
  output logic                              out_last,
  output logic                              busy
);

  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int OW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [OW-1:0]                  oidx_q, oidx_d;
  logic [SLW-1:0]                 step_q, step_d;
  logic [SLW-1:0]                 len_q, len_d;
  logic [D-1:0][DATA_WIDTH-1:0]   x_q, x_d;
  logic [H-1:0][DATA_WIDTH-1:0]   h_q, h_d;
  logic                           in_ready_q, in_ready_d;
  logic                           cell_start_q, cell_start_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
  logic                           busy_q, busy_d;
  logic [SLW-1:0]                 len_clamped;

  assign len_clamped = (seq_len > SLW'(T_MAX)) ? SLW'(T_MAX) : seq_len;

  // Next-state logic; every output is derived from the next state so it is registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oidx_d  = oidx_q;
    step_d  = step_q;
    len_d   = len_q;
    x_d     = x_q;
    h_d     = h_q;
    case (state_q)
      IDLE: begin
        if (seq_start) begin
          h_d     = '0;
          step_d  = '0;
          idx_d   = '0;
          oidx_d  = '0;
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          x_d[idx_q] = in_data;
          if (idx_q == IW'(D - 1)) begin
            idx_d   = '0;
            state_d = FIRE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        // Only a done seen after our own FIRE is honoured; stale ones land in other states.
        if (cell_done) begin
          h_d = cell_h_t;
          if (step_q + SLW'(1) == len_q) begin
            state_d = DRAIN;
          end else begin
            step_d  = step_q + SLW'(1);
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (oidx_q == OW'(H - 1)) begin
            oidx_d  = '0;
            state_d = IDLE;
          end else begin
            oidx_d = oidx_q + OW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d   = (state_d == LOAD);
    cell_start_d = (state_d == FIRE);
    out_valid_d  = (state_d == DRAIN);
    out_last_d   = (state_d == DRAIN) && (oidx_d == OW'(H - 1));
    out_data_d   = (state_d == DRAIN) ? h_d[oidx_d] : '0;
    busy_d       = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      oidx_q       <= '0;
      step_q       <= '0;
      len_q        <= '0;
      x_q          <= '0;
      h_q          <= '0;
      in_ready_q   <= 1'b0;
      cell_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      oidx_q       <= oidx_d;
      step_q       <= step_d;
      len_q        <= len_d;
      x_q          <= x_d;
      h_q          <= h_d;
      in_ready_q   <= in_ready_d;
      cell_start_q <= cell_start_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign cell_start  = cell_start_q;
  assign cell_x_t    = x_q;
  assign cell_h_prev = h_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gru_sequence_controller.sv
// Directed bench for gru_sequence_controller with a behavioural cell:
// h_t[k] = h_prev[k] + x_t[k], reported five cycles after cell_start.
`timescale 1ns/1ps
module tb_gru_sequence_controller;

  localparam int D = 4;
  localparam int H = 2;
  localparam int DW = 15;
  localparam int TM = 4;
  localparam int SLW = $clog2(TM + 1);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   seq_start = 1'b0;
  logic [SLW-1:0]         seq_len = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [DW-1:0]   in_data = '0;
  logic                   cell_start;
  logic [D-1:0][DW-1:0]   cell_x_t;
  logic [H-1:0][DW-1:0]   cell_h_prev;
  logic [H-1:0][DW-1:0]   cell_h_t;
  logic                   cell_done;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [DW-1:0]   out_data;
  logic                   out_last;
  logic                   busy;

  gru_sequence_controller #(.D(D), .H(H), .DATA_WIDTH(DW), .T_MAX(TM)) dut (
    .clk(clk), .rst_n(rst_n), .seq_start(seq_start), .seq_len(seq_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cell_start(cell_start), .cell_x_t(cell_x_t), .cell_h_prev(cell_h_prev),
    .cell_h_t(cell_h_t), .cell_done(cell_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural cell; its counter ignores reset so an aborted run yields a stale done.
  int            cnt = 0;
  logic          man_done = 1'b0;
  logic [DW-1:0] man_h = '0;
  assign cell_done = (cnt == 1) || man_done;
  always_comb begin
    for (int k = 0; k < H; k++)
      cell_h_t[k] = man_done ? man_h : DW'(cell_h_prev[k] + cell_x_t[k]);
  end

  // Monitors
  int cyc = 0, acc_cnt = 0, last_acc = -100, start_cnt = 0;
  int gap_bad = 0, width_bad = 0, stab_bad = 0;
  logic prev_start = 1'b0;
  int out_q[$];
  int last_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_start <= cell_start;
    if (cell_start) cnt <= 5;
    else if (cnt > 0) cnt <= cnt - 1;
    if (in_valid && in_ready) begin
      acc_cnt <= acc_cnt + 1;
      last_acc <= cyc;
    end
    if (cell_start) begin
      start_cnt <= start_cnt + 1;
      if (cyc - last_acc != 1) gap_bad <= gap_bad + 1;
      if (prev_start) width_bad <= width_bad + 1;
    end
    if (out_valid && out_ready) begin
      out_q.push_back(int'($signed(out_data)));
      last_q.push_back(int'(out_last));
    end
  end

  int n_chk = 0, n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int stim[$];

  task automatic run_seq(input string nm, input int len, input int toggle, input int stall,
                         input int poke, input int exp_starts, input int e0, input int e1);
    int sbase, abase, obase, n_el, guard, phase, poked, st, first;
    logic [DW-1:0] held;
    sbase = start_cnt; abase = acc_cnt; obase = out_q.size(); n_el = stim.size();
    phase = 0; poked = 0; held = '0;
    @(negedge clk);
    seq_start = 1'b1;
    seq_len = SLW'(len);
    in_valid = (n_el > 0) && (toggle == 0);
    in_data = (n_el > 0) ? DW'(stim[0]) : '0;
    @(negedge clk);
    seq_start = 1'b0;
    check_eq({nm, "_busy"}, int'(busy), 1);
    check_eq({nm, "_idle_acc"}, acc_cnt - abase, 0);
    guard = 0;
    while (acc_cnt - abase < n_el && guard < 1000) begin
      in_data = DW'(stim[acc_cnt - abase]);
      in_valid = (toggle != 0) ? phase[0] : 1'b1;
      phase ^= 1;
      if (poke != 0 && poked == 0 && start_cnt > sbase) begin
        seq_start = 1'b1; seq_len = SLW'(1); poked = 1;
      end else begin
        seq_start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    seq_start = 1'b0;
    check_eq({nm, "_fed"}, acc_cnt - abase, n_el);
    guard = 0; st = stall; first = 1;
    while (out_q.size() - obase < H && guard < 1000) begin
      if (out_valid && st > 0) begin
        out_ready = 1'b0;
        if (first != 0) held = out_data;
        else if (out_data !== held) stab_bad++;
        first = 0;
        st--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b1;
    check_eq({nm, "_drained"}, out_q.size() - obase, H);
    if (out_q.size() - obase >= H) begin
      check_eq({nm, "_out0"}, out_q[obase], e0);
      check_eq({nm, "_out1"}, out_q[obase + 1], e1);
      check_eq({nm, "_last0"}, last_q[obase], 0);
      check_eq({nm, "_last1"}, last_q[obase + 1], 1);
    end
    check_eq({nm, "_starts"}, start_cnt - sbase, exp_starts);
    check_eq({nm, "_busy_end"}, int'(busy), 0);
    $display("seq %s len=%0d starts=%0d out=(%0d,%0d)", nm, len, start_cnt - sbase,
             (out_q.size() > obase) ? out_q[obase] : 0,
             (out_q.size() > obase + 1) ? out_q[obase + 1] : 0);
  endtask

  initial begin
    int sbase, abase, guard;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_cell_start", int'(cell_start), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_h_prev", int'(cell_h_prev), 0);
    check_eq("rst_x_zero", int'(cell_x_t != '0), 0);

    // done while idle must not capture anything
    man_h = DW'(77); man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    check_eq("idle_done_h", int'(cell_h_prev), 0);
    check_eq("idle_done_busy", int'(busy), 0);

    stim = '{1, 2, 3, 4, 10, 20, 30, 40, 100, 200, 300, 400};
    run_seq("basic", 3, 0, 0, 0, 3, 111, 222);
    run_seq("bpress", 3, 1, 3, 0, 3, 111, 222);
    check_eq("stall_stable", stab_bad, 0);

    stim = {};
    run_seq("len0", 0, 0, 0, 0, 0, 0, 0);

    stim = '{1, 2, 0, 0, 2, 4, 0, 0, 3, 6, 0, 0, 4, 8, 0, 0};
    run_seq("clamp", 7, 0, 0, 0, 4, 10, 20);

    stim = '{-30, 4, 0, 0, 5, 6, 0, 0};
    run_seq("poke", 2, 0, 0, 1, 2, -25, 10);

    // Reset while the cell is computing, then a stale done
    sbase = start_cnt; abase = acc_cnt;
    @(negedge clk);
    seq_start = 1'b1; seq_len = SLW'(2);
    @(negedge clk);
    seq_start = 1'b0;
    guard = 0;
    while ((acc_cnt - abase < 4 || start_cnt == sbase) && guard < 200) begin
      in_valid = (acc_cnt - abase < 4);
      in_data = DW'(acc_cnt - abase + 1);
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check_eq("wrst_started", start_cnt - sbase, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("wrst_busy", int'(busy), 0);
    check_eq("wrst_in_ready", int'(in_ready), 0);
    check_eq("wrst_x_zero", int'(cell_x_t != '0), 0);
    rst_n = 1'b1;
    man_h = DW'(99); man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("stale_h", int'(cell_h_prev), 0);
    check_eq("stale_busy", int'(busy), 0);
    check_eq("stale_out_valid", int'(out_valid), 0);

    stim = '{5, 6, 7, 8};
    run_seq("after_rst", 1, 0, 0, 0, 1, 5, 6);

    check_eq("start_gap", gap_bad, 0);
    check_eq("start_width", width_bad, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/gru_sequence_controller.md
Name: gru_sequence_controller

Overview:
- Upstream/feedback stage for gru_cell_parallel.
- Accepts a sequence of input vectors as an element stream and assembles each D-element x_t, then pulses the cell's start and waits for done.
- Latches the cell's h_t into its hidden-state register, which feeds back as h_t_prev on the next timestep.
- After seq_len timesteps, streams the final hidden state out element-by-element.

Parameters:
D, 64, input vector length (elements per x_t)
H, 16, hidden state length
DATA_WIDTH, 15, signed fixed-point element width
T_MAX, 32, maximum sequence length; SLW = $clog2(T_MAX+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
seq_start  in  1  pulse: begin new sequence (sampled only in IDLE)
seq_len  in  SLW  number of timesteps, sampled with seq_start
in_valid  in  1  input element valid
in_ready  out  1  input element accepted when in_valid & in_ready
in_data  in  DATA_WIDTH signed  input element, x index order 0..D-1, timesteps back-to-back
cell_start  out  1  one-cycle start pulse to cell
cell_x_t  out  DATA_WIDTH x D  assembled x_t buffer
cell_h_prev  out  DATA_WIDTH x H  hidden-state register
cell_h_t  in  DATA_WIDTH x H  cell result
cell_done  in  1  cell completion pulse
out_valid  out  1  final hidden element valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  DATA_WIDTH signed  final hidden element, index 0..H-1
out_last  out  1  high with element H-1
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async): state=IDLE; x buffer, h register, step counter, element counters=0. in_ready=0, cell_start=0, out_valid=0, out_last=0, busy=0, out_data=0.
- Reset mid-operation aborts everything. The cell has no abort, so after reset the controller ignores cell_done until it issues its own cell_start.
- States: IDLE, LOAD, FIRE, WAIT, DRAIN.
- IDLE:
  - On seq_start: clear h register to 0, step=0, len=min(seq_len,T_MAX).
  - len==0 -> DRAIN (outputs all-zero h); else -> LOAD.
  - seq_start outside IDLE is ignored.
- LOAD:
  - in_ready=1. Each accepted element is written to x_buf[idx] and idx increments.
  - On accepting idx==D-1: idx=0, next state FIRE. in_ready drops the following cycle, so there is no extra acceptance.
- FIRE: cell_start=1 for exactly this cycle; -> WAIT.
- WAIT:
  - in_ready=0; x_buf and h register held stable, since the cell reads them combinationally while computing.
  - On cell_done: h_reg <= cell_h_t on the same edge; step++.
  - If step+1==len -> DRAIN, else -> LOAD. in_ready is high the cycle after cell_done.
- cell_done outside WAIT is ignored.
- DRAIN:
  - out_valid=1; out_data=h_reg[oidx]; out_last=(oidx==H-1).
  - out_data/out_last are held while out_valid & !out_ready.
  - On handshake: oidx++. On last handshake: oidx=0, -> IDLE, out_valid=0 next cycle.
- Latency per timestep = D accept cycles (min) + 1 FIRE + cell latency + 0 (done->h capture on the same edge).
- busy=1 from the cycle after accepted seq_start until the cycle after the last out handshake.
- Arithmetic:
  - Counters are unsigned, sized $clog2 of their bound.
  - No wrap: idx never exceeds D-1, oidx never exceeds H-1, step never exceeds len-1.
  - Data is passed through bit-exact; no scaling or saturation.
- Simultaneous seq_start and in_valid in IDLE: the element is not accepted (in_ready=0 in IDLE).

Test Plan:
- Bench: D=4, H=2, T_MAX=4. Behavioural cell returns h_t[k]=h_prev[k]+x_t[k] after 5 cycles.
- Reset then idle: all outputs 0, in_ready=0, busy=0; pulse cell_done -> no state change.
- seq_len=3, inputs x=(1,2,3,4),(10,20,30,40),(100,200,300,400):
  - exactly 3 cell_start pulses, each one cycle, 1 cycle after 4th element;
  - out stream 111,222, out_last on 222.
- Backpressure: in_valid toggled 50% and out_ready low 3 cycles during DRAIN -> same 111,222; out_data stable while stalled; no element lost or duplicated.
- seq_len=0 -> no cell_start; out stream 0,0 with out_last on second. seq_len=7 -> clamped to 4 cell_start pulses.
- Second sequence after first: h restarts at 0. seq_start pulsed during WAIT is ignored (step count unchanged).
- Async reset asserted during WAIT, then a stale cell_done -> IDLE, h=0, no capture. A new sequence seq_len=1, x=(5,6,7,8) -> out 5,6.
